morph_nxn: RTL

- Parametrised binary morphology block: dilation or erosion over a KSIZE x KSIZE square window.
- Sits after binarisation and before display/ROI logic in the adaptive-threshold segmentation chain.
- Successor to the fixed 3x3 dilate stage, adding:
  - selectable kernel size (3 or 5);
  - runtime erode/dilate mode, latched per frame;
  - explicit frame-border padding;
  - matched sync delay.

---
 rtl/morph_pkg.sv | 13 +
 rtl/morph_window.sv | 99 +++++++++
 rtl/morph_nxn.sv | 118 +++++++++++
 3 files changed

// File: rtl/morph_pkg.sv
// rtl/morph_pkg.sv - shared encodings and constants for the morph_nxn block
package morph_pkg;

    localparam logic MORPH_DILATE = 1'b0;
    localparam logic MORPH_ERODE  = 1'b1;
    localparam int   LATENCY      = 3;

    // Padding must be the identity of the reduction: 0 for OR, 1 for AND.
    function automatic logic pad_of(input logic mode);
        return (mode == MORPH_ERODE);
    endfunction

endpackage

// File: rtl/morph_window.sv
// rtl/morph_window.sv - line buffers, KSIZE x KSIZE window, raster counters and border padding
module morph_window
    import morph_pkg::*;
#(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480,
    parameter int KSIZE  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic                     in_de,
    input  logic                     in_vsync,
    input  logic                     pix,
    output logic [KSIZE*KSIZE-1:0]   win,
    output logic                     win_valid,
    output logic                     win_mode
);

    localparam int KM1 = KSIZE - 1;
    localparam int CW  = $clog2(H_DISP);
    localparam int RW  = $clog2(V_DISP);

    logic            vsync_q;
    logic            mode_q;
    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;
    logic            vs_rise;
    logic [CW-1:0]   col_eff;
    logic [RW-1:0]   row_eff;
    logic            mode_eff;
    logic            pad;

    // lb[c] bit k holds the pixel of row r-1-k at column c.
    logic [KM1-1:0]        lb [H_DISP];
    logic [KSIZE-1:0]      col_new;
    logic [KM1*KSIZE-1:0]  hist;
    logic [KSIZE*KSIZE-1:0] win_d;

    // A pixel coinciding with the vsync edge already belongs to the new frame.
    assign vs_rise  = in_vsync & ~vsync_q;
    assign col_eff  = vs_rise ? '0 : col_cnt;
    assign row_eff  = vs_rise ? '0 : row_cnt;
    assign mode_eff = vs_rise ? mode : mode_q;
    assign pad      = pad_of(mode_eff);

    assign col_new[KM1] = pix;
    for (genvar gk = 0; gk < KM1; gk++) begin : g_lb_rd
        assign col_new[KM1-1-gk] = (int'(row_eff) < gk + 1) ? pad : lb[col_eff][gk];
    end

    // hist column j holds image column c-(KM1-j); columns left of the frame are padded.
    for (genvar gi = 0; gi < KSIZE; gi++) begin : g_row
        assign win_d[gi*KSIZE+KM1] = col_new[gi];
        for (genvar gj = 0; gj < KM1; gj++) begin : g_col
            assign win_d[gi*KSIZE+gj] = (int'(col_eff) < KM1 - gj) ? pad : hist[gj*KSIZE+gi];
        end
    end

    always_ff @(posedge clk) begin
        if (in_de) begin
            lb[col_eff] <= {lb[col_eff][KM1-2:0], pix};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= 1'b0;
            mode_q    <= MORPH_DILATE;
            col_cnt   <= '0;
            row_cnt   <= '0;
            hist      <= '0;
            win       <= '0;
            win_valid <= 1'b0;
            win_mode  <= MORPH_DILATE;
        end else begin
            vsync_q   <= in_vsync;
            win_valid <= in_de;
            if (vs_rise) begin
                col_cnt <= '0;
                row_cnt <= '0;
                mode_q  <= mode;
            end
            if (in_de) begin
                hist     <= {col_new, hist[KM1*KSIZE-1:KSIZE]};
                win      <= win_d;
                win_mode <= mode_eff;
                if (col_eff == CW'(H_DISP - 1)) begin
                    col_cnt <= '0;
                    row_cnt <= (row_eff == RW'(V_DISP - 1)) ? '0 : row_eff + RW'(1);
                end else begin
                    col_cnt <= col_eff + CW'(1);
                    row_cnt <= row_eff;
                end
            end
        end
    end

endmodule

// File: rtl/morph_nxn.sv
// rtl/morph_nxn.sv - binary dilate/erode over a KSIZE x KSIZE window; MORPH_FG_CNT_EN adds fg_count
module morph_nxn
    import morph_pkg::*;
#(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480,
    parameter int KSIZE  = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_de,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_de,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic [DATA_W-1:0] out_data
`ifdef MORPH_FG_CNT_EN
    ,
    output logic [$clog2(H_DISP*V_DISP+1)-1:0] fg_count
`endif
);

    if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
        $error("morph_nxn: KSIZE must be 3 or 5");
    end

    logic [KSIZE*KSIZE-1:0] win;
    logic                   win_valid;
    logic                   win_mode;
    logic [KSIZE-1:0]       row_red_d;
    logic [KSIZE-1:0]       row_red_q;
    logic                   s1_mode;
    logic                   s1_valid;
    logic                   res_q;
    logic [LATENCY-1:0]     de_sr;
    logic [LATENCY-1:0]     hs_sr;
    logic [LATENCY-1:0]     vs_sr;

    morph_window #(
        .H_DISP (H_DISP),
        .V_DISP (V_DISP),
        .KSIZE  (KSIZE)
    ) u_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_de     (in_de),
        .in_vsync  (in_vsync),
        .pix       (|in_data),
        .win       (win),
        .win_valid (win_valid),
        .win_mode  (win_mode)
    );

    for (genvar gi = 0; gi < KSIZE; gi++) begin : g_red
        assign row_red_d[gi] = (win_mode == MORPH_DILATE) ? |win[gi*KSIZE +: KSIZE]
                                                          : &win[gi*KSIZE +: KSIZE];
    end

    // Result is forced low in blanking so out_data is clean when out_de is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_red_q <= '0;
            s1_mode   <= MORPH_DILATE;
            s1_valid  <= 1'b0;
            res_q     <= 1'b0;
            de_sr     <= '0;
            hs_sr     <= '0;
            vs_sr     <= '0;
        end else begin
            row_red_q <= row_red_d;
            s1_mode   <= win_mode;
            s1_valid  <= win_valid;
            res_q     <= s1_valid & ((s1_mode == MORPH_DILATE) ? |row_red_q : &row_red_q);
            de_sr     <= {de_sr[LATENCY-2:0], in_de};
            hs_sr     <= {hs_sr[LATENCY-2:0], in_hsync};
            vs_sr     <= {vs_sr[LATENCY-2:0], in_vsync};
        end
    end

    assign out_de    = de_sr[LATENCY-1];
    assign out_hsync = hs_sr[LATENCY-1];
    assign out_vsync = vs_sr[LATENCY-1];
    assign out_data  = {DATA_W{res_q}};

`ifdef MORPH_FG_CNT_EN
    localparam int FG_W = $clog2(H_DISP*V_DISP+1);

    logic            out_vsync_q;
    logic [FG_W-1:0] fg_acc;
    logic            hit;
    logic            ovs_rise;

    assign hit      = out_de & res_q;
    assign ovs_rise = out_vsync & ~out_vsync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vsync_q <= 1'b0;
            fg_acc      <= '0;
            fg_count    <= '0;
        end else begin
            out_vsync_q <= out_vsync;
            if (ovs_rise) begin
                fg_count <= fg_acc;
                fg_acc   <= hit ? FG_W'(1) : '0;
            end else if (hit) begin
                fg_acc <= fg_acc + FG_W'(1);
            end
        end
    end
`endif

endmodule
